// File: rtl/axis_pkg.sv
// Shared AXI-Stream types and helpers for the stream FIFO slice.
package axis_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int AXIS_ID_W   = 1;
    localparam int AXIS_DEST_W = 1;
    localparam int AXIS_USER_W = 1;

    // One stored beat at the default widths; field order matches the flat
    // packing used inside the FIFO (data in the MSBs, user in the LSBs).
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] strb;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
        logic [AXIS_ID_W-1:0]   id;
        logic [AXIS_DEST_W-1:0] dest;
        logic [AXIS_USER_W-1:0] user;
    } AXIS_BEAT_T;

    // Packed width of one beat for an arbitrary set of field widths.
    function automatic int axis_beat_width(input int data_w, input int id_w,
                                           input int dest_w, input int user_w);
        return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: one write port, one
// registered read port with enable. Storage is intentionally not reset.
module axis_fifo_ram #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming beat at the write address.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; this register doubles as the FIFO head register.
    always_ff @(posedge clk) begin
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO with first-word-fall-through output and an
// optional store-and-forward mode that holds packets until their tlast
// beat has arrived.
module axis_fifo
    import axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [TDATA_WIDTH-1:0]     s_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   s_tstrb,
    input  logic [TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                       s_tlast,
    input  logic [TID_WIDTH-1:0]       s_tid,
    input  logic [TDEST_WIDTH-1:0]     s_tdest,
    input  logic [TUSER_WIDTH-1:0]     s_tuser,

    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [TDATA_WIDTH-1:0]     m_tdata,
    output logic [TDATA_WIDTH/8-1:0]   m_tstrb,
    output logic [TDATA_WIDTH/8-1:0]   m_tkeep,
    output logic                       m_tlast,
    output logic [TID_WIDTH-1:0]       m_tid,
    output logic [TDEST_WIDTH-1:0]     m_tdest,
    output logic [TUSER_WIDTH-1:0]     m_tuser,

    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = axis_beat_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW + 1)'(1);

    // Pointers carry a wrap bit above the address bits.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_next;
    logic [AW:0]   rd_next;
    logic [AW:0]   level_next;

    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          valid_int;
    logic          ready_q;
    logic          oversize_q;
    logic          bypass_set;
    logic          bypass_q;
    logic          ram_ren;

    logic [BW-1:0] s_beat;
    logic [BW-1:0] bypass_beat;
    logic [BW-1:0] ram_rdata;
    logic [BW-1:0] head_beat;

    assign s_beat = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push = s_tvalid && ready_q;
    assign pop  = valid_int && m_tready;

    assign wr_next    = wr_ptr + {{AW{1'b0}}, push};
    assign rd_next    = rd_ptr + {{AW{1'b0}}, pop};
    assign level_next = wr_next - rd_next;
    assign level      = wr_ptr - rd_ptr;

    // When the beat being written is also the next head, the RAM cannot
    // return it in time, so a registered copy of the input supplies it.
    assign bypass_set = push && (wr_ptr == rd_next);
    assign ram_ren    = !bypass_set;

    assign head_beat = bypass_q ? bypass_beat : ram_rdata;
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = head_beat;

    assign s_tready = ready_q;
    assign m_tvalid = valid_int;

    axis_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .wen   (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (s_beat),
        .ren   (ram_ren),
        .raddr (rd_next[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Output valid: any stored beat in cut-through, only whole packets (or an
    // oversize packet that has filled the FIFO) in store-and-forward.
    always_comb begin
        valid_int = !empty;
        if (PACKET_MODE != 0) begin
            valid_int = !empty && ((pkt_count != '0) || full || oversize_q);
        end
    end

    // Advance the pointers and register the ready flag from the next level
    // so that s_tready never depends on this cycle's handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            ready_q <= (level_next < FULL_LEVEL);
        end
    end

    // Count stored tlast beats, i.e. complete packets held in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count <= '0;
        end else begin
            case ({push && s_tlast, pop && m_tlast})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    // A packet that fills the FIFO without a tlast is released cut-through
    // until its tlast leaves, otherwise it would deadlock.
    always_ff @(posedge clk) begin
        if (rst || (PACKET_MODE == 0)) begin
            oversize_q <= 1'b0;
        end else if (pop && m_tlast) begin
            oversize_q <= 1'b0;
        end else if (full && (pkt_count == '0)) begin
            oversize_q <= 1'b1;
        end
    end

    // Remember whether the head comes from the bypass copy or from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_set;
        end
    end

    // Capture the input beat that will become the head next cycle.
    always_ff @(posedge clk) begin
        if (bypass_set) begin
            bypass_beat <= s_beat;
        end
    end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Parametrised synchronous AXI-Stream FIFO, one clock domain, with configurable data, ID, DEST and USER widths and configurable depth.
- Optional packet (store-and-forward) mode: the output only presents a packet once its tlast beat is stored.
- Sits between Ethernet MAC/UDP stream stages to absorb backpressure and to buffer whole frames ahead of consumers that must not stall mid-packet.

Parameters:
- TDATA_WIDTH, 32, data width in bits; multiple of 8.
- TID_WIDTH, 1, tid width; minimum 1.
- TDEST_WIDTH, 1, tdest width; minimum 1.
- TUSER_WIDTH, 1, tuser width; minimum 1.
- DEPTH, 16, beat capacity; power of two, ≥ 2.
- PACKET_MODE, 0, 1 = store-and-forward, 0 = cut-through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_tvalid  in  1  slave beat valid.
- s_tready  out  1  slave ready.
- s_tdata  in  TDATA_WIDTH  slave data.
- s_tstrb  in  TDATA_WIDTH/8  slave byte strobe.
- s_tkeep  in  TDATA_WIDTH/8  slave byte keep.
- s_tlast  in  1  slave end of packet.
- s_tid  in  TID_WIDTH  slave stream ID.
- s_tdest  in  TDEST_WIDTH  slave destination.
- s_tuser  in  TUSER_WIDTH  slave sideband.
- m_tvalid  out  1  master beat valid.
- m_tready  in  1  master ready.
- m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  widths as slave  master beat fields.
- level  out  $clog2(DEPTH)+1  beats stored.
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (tlast beats).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high, sampled on the rising edge of `clk`.
- Reset values: level=0, pkt_count=0, m_tvalid=0, s_tready=0 during rst. Pointers are cleared. Payload outputs are don't-care.
- s_tready rises the first cycle after rst deasserts.
- Reset mid-operation: all stored beats are discarded. No partial packet survives.
- Write: occurs on s_tvalid && s_tready; the whole beat is stored. s_tready = (level < DEPTH), registered; it must not depend combinationally on s_tvalid.
- Read: first-word-fall-through. The head beat is presented on the m_* fields whenever m_tvalid=1. A pop occurs on m_tvalid && m_tready.
- Payload stability: m_* payload and m_tvalid are held stable while m_tvalid && !m_tready.
- Latency: a beat written in cycle N is visible with m_tvalid=1 no earlier than cycle N+1 in cut-through mode.
- There is no combinational path from s_* to m_*, and none from m_tready to s_tready.
- Full: s_tready=0. A pop in the same cycle does not allow a write in that cycle; s_tready rises the next cycle.
- Empty: m_tvalid=0. A write into an empty FIFO never bypasses to the output in the same cycle.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both complete.
- level: +1 on push only, -1 on pop only, unchanged on both. Range 0..DEPTH.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. full = addresses equal and wrap bits differ; empty = pointers equal. Wrap-around is exercised continuously.
- pkt_count: +1 on a push with s_tlast=1, -1 on a pop with m_tlast=1, unchanged when both occur.
- PACKET_MODE=1 gating: m_tvalid = !empty && (pkt_count>0 || full).
- PACKET_MODE=1, full with no tlast stored (oversize packet): the FIFO switches to cut-through for that packet so it cannot deadlock. Gating resumes after that packet's tlast is popped.
- PACKET_MODE=0: m_tvalid = !empty.
- twakeup is not carried; the wrapper at the interface-instance level ties it off.
- Storage: one simple dual-port memory. Write port on push; read port prefetches the head into an output register to give FWFT with registered outputs.

Decomposition:
- Package axis_pkg holds the AXIS_BEAT_T packed struct (data, strb, keep, last, id, dest, user), parametrised via width localparams.
- axis_pkg also holds the function axis_beat_width() that returns the packed beat width.
- Sub-module axis_fifo_ram: a simple dual-port RAM with DEPTH × beat width, synchronous write, synchronous read with read enable. It has no reset on its storage.
- axis_fifo contains the pointers, level, pkt_count, output prefetch register and packet gating.

Test Plan:
- Reset then idle; DEPTH=16 → level=0, m_tvalid=0. Payload 0xA5A5_0001 written at cycle 5 → m_tvalid=1 at cycle 6 with m_tdata=0xA5A5_0001, level=1.
- Fill 16 beats with m_tready=0 → s_tready=0 after the 16th push, level=16. Pop one beat → s_tready=1 the next cycle, and no write accepted in the pop cycle.
- 1000 beats of an incrementing pattern with random s_tvalid/m_tready (50%) → output sequence identical to input across ≥60 pointer wraps. level always equals pushes minus pops.
- PACKET_MODE=1, 4-beat packet with 3 cycles between beats → m_tvalid stays 0 until the cycle after the tlast push, then the 4 beats stream out contiguously with m_tready=1, and pkt_count goes 1→0.
- PACKET_MODE=1, DEPTH=8, 12-beat packet → FIFO fills, m_tvalid asserts while full, all 12 beats are delivered in order with no deadlock, and pkt_count ends at 0.
- rst asserted with level=5 and a packet half-written → the next cycle level=0, pkt_count=0, m_tvalid=0. A following 2-beat packet emerges with no stale data.
